// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage pipeline.
// Resolves per-stage stall requests into a hold vector where the highest
// requesting stage wins. It also detects load-use hazards, tracks data-memory
// waits with a timeout, issues branch flushes and counts stalled cycles.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifBusy,
  input  logic [4:0]       idRs1,
  input  logic [4:0]       idRs2,
  input  logic             idUseRs2,
  input  logic [4:0]       exALUop,
  input  logic [4:0]       exWriteNum,
  input  logic             exBusy,
  input  logic             exBranchTaken,
  input  logic [31:0]      exBranchTarget,
  input  logic             memReq,
  input  logic             memAck,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      flushPC,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam logic [4:0] OP_LW = 5'b10100;

  // The wait counter only ever reaches MEM_TIMEOUT-1, so clog2 bits suffice.
  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              err_set;

  logic              mem_ack_eff;
  logic              mem_stall;
  logic              high_stall;
  logic              flush_raw;
  logic              load_use;
  logic [5:0]        stall_raw;

  // Stall/flush request resolution; outputs are combinational from inputs and state.
  always_comb begin
    // A request that disappears while waiting counts as completion.
    mem_ack_eff = memAck | ~memReq;
    if (state == ST_RUN) begin
      mem_stall = memReq & ~memAck;
    end else begin
      mem_stall = ~mem_ack_eff;
    end

    // Stalls at EX or beyond keep a resolved branch in EX, so it cannot flush yet.
    high_stall = mem_stall | exBusy;
    flush_raw  = exBranchTaken & ~high_stall;

    // A flushed ID instruction is wrong-path, so its hazard is irrelevant.
    load_use = (exALUop == OP_LW) && (exWriteNum != 5'd0) &&
               ((exWriteNum == idRs1) || (idUseRs2 && (exWriteNum == idRs2))) &&
               !flush_raw;

    if (mem_stall) begin
      stall_raw = 6'b011111;
    end else if (exBusy) begin
      stall_raw = 6'b001111;
    end else if (load_use) begin
      stall_raw = 6'b000111;
    end else if (ifBusy) begin
      stall_raw = 6'b000011;
    end else begin
      stall_raw = 6'b000000;
    end

    // While reset is held, the pipeline sees no holds and no flush.
    if (rst) begin
      stall   = 6'b000000;
      flush   = 1'b0;
      flushPC = 32'd0;
    end else begin
      stall   = stall_raw;
      flush   = flush_raw;
      flushPC = flush_raw ? exBranchTarget : 32'd0;
    end
  end

  // Next-state logic for the memory-wait sequencer, including the timeout abort.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_set       = 1'b0;
    case (state)
      ST_RUN: begin
        if (memReq && !memAck) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_eff) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
          err_set       = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Sequencer state, the sticky timeout flag and the saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      memErr      <= 1'b0;
      stallCycles <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (err_set) begin
        memErr <= 1'b1;
      end
      if (stall[0] && (stallCycles != {CNT_W{1'b1}})) begin
        stallCycles <= stallCycles + CNT_W'(1);
      end
    end
  end

endmodule
